cond_flag_eval: RTL and testbench
=================================

Name: cond_flag_eval

Overview:
- Consumer side of the NZCV flag interface driven by the compare/subtract unit.
- Holds the architectural NZCV register and evaluates 4-bit ARM-style condition codes against it.
- Condition requests use a valid/ready handshake and return a registered taken/error result.
- Stalls while a compare is in flight; issues a timeout error if the flags never arrive.

Parameters:
PEND_TIMEOUT, 16, max cycles a request waits for fresh flags before an error response (legal range ≥2).

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
flg_pend  in  1  pulse: compare issued; held flags become stale
flg_valid  in  1  pulse: new flags on flg_n/z/c/v
flg_n  in  1  negative flag
flg_z  in  1  zero flag
flg_c  in  1  carry flag
flg_v  in  1  overflow flag
req_valid  in  1  condition request valid
req_ready  out  1  block can accept a request
req_cond  in  4  condition code
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
res_taken  out  1  condition true
res_err  out  1  NV code or timeout
flags_out  out  4  held {N,Z,C,V}
busy  out  1  state != IDLE

Behaviour:
- Reset (rst high at clk edge; wins over all other inputs, including mid-transaction):
  - flags register = 4'b0000; flags_ok = 0; state = IDLE.
  - res_valid = res_taken = res_err = 0; busy = 0; timeout counter = 0.
  - Any in-flight request is dropped.
- Flag register update:
  - flg_valid: load {n,z,c,v} and set flags_ok = 1 next cycle.
  - flg_pend: clear flags_ok.
  - Both in the same cycle: load the flags, but flags_ok = 0 (pend wins; the loaded flags are older than the issued compare).
- Handshake rules:
  - req_ready = (state == IDLE). A request is accepted when req_valid && req_ready; req_cond is latched.
  - res_* are stable while res_valid=1 && !res_ready.
- State machine:
  - IDLE:
    - On accept with flags_ok=1, go to RESP with a result evaluated from the held flags. Latency is one cycle: accept at T, res_valid at T+1.
    - On accept with flags_ok=0, go to WAIT; counter = 0.
  - WAIT:
    - Each cycle: if flags_ok=1, evaluate and go to RESP.
    - Otherwise increment the counter. At counter == PEND_TIMEOUT-1, go to RESP with res_err=1, res_taken=0.
    - flg_pend arriving during WAIT keeps the block waiting; the counter is not restarted.
  - RESP:
    - res_valid=1, held until res_ready; then IDLE.
    - res_ready in the same cycle res_valid rises completes the transfer in that cycle.
    - The next request can be accepted the cycle after completion.
- Condition evaluation (combinational on the latched cond and the selected flags):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F NV: taken=0, err=1
- Counter width is $clog2(PEND_TIMEOUT). It does not run outside WAIT.

Optional Feature:
FLAG_FWD_EN
- Defined: flags arriving via flg_valid (without flg_pend) in the same cycle are forwarded to evaluation.
  - In WAIT, flg_valid at T gives res_valid at T+1.
  - In IDLE with flags_ok=0, an accept coinciding with flg_valid goes directly to RESP (res_valid T+1).
- Undefined: evaluation uses only the registered flags.
  - In WAIT, flg_valid at T gives res_valid at T+2.
  - An IDLE accept with flags_ok=0 always goes through WAIT.

Decomposition:
- Shared package alu_cond_pkg holds:
  - condition-code localparams (COND_EQ … COND_NV);
  - NZCV bit indices (N=3, Z=2, C=1, V=0);
  - the state enum (IDLE, WAIT, RESP).
- One sub-module, cond_decode: purely combinational {cond, nzcv} → {taken, err}. It is reusable by the branch unit.

Test Plan:
1. Reset, then flg_valid with NZCV=0100; request EQ (0x0) → res_valid 1 cycle after accept, taken=1, err=0; NE (0x1) → taken=0.
2. Flags NZCV=1001 (N=V); request GE (0xA) → taken=1; LT (0xB) → taken=0; GT (0xC) → taken=1; NV (0xF) → taken=0, err=1.
3. flg_pend, then request HI (0x8); flg_valid with NZCV=0010 five cycles later → res_valid at flg_valid+2 (+1 with FLAG_FWD_EN), taken=1.
4. flg_pend with no flg_valid; request AL (0xE) → res_valid exactly PEND_TIMEOUT cycles after the WAIT entry, err=1, taken=0; flags_out unchanged.
5. Hold res_ready=0 for 4 cycles in RESP → res_* stable and req_ready=0; then res_ready=1 → IDLE next cycle. flg_pend+flg_valid in the same cycle → flags_out updated, the next request waits.
6. Assert rst while in WAIT and while in RESP → all outputs 0 and flags_out=0 the next cycle; a subsequent request waits for flg_valid.

Source files
------------

// File: rtl/alu_cond_pkg.sv
// Shared definitions for NZCV condition evaluation: condition codes, flag bit
// positions and the cond_flag_eval state encoding.
package alu_cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/cond_flag_eval_if.sv
// Condition request / result handshake between a requester and cond_flag_eval.
interface cond_flag_eval_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_cond;
  logic       res_valid;
  logic       res_ready;
  logic       res_taken;
  logic       res_err;

  modport master (
    output req_valid, req_cond, res_ready,
    input  req_ready, res_valid, res_taken, res_err
  );

  modport slave (
    input  req_valid, req_cond, res_ready,
    output req_ready, res_valid, res_taken, res_err
  );
endinterface

// File: rtl/cond_decode.sv
// Combinational ARM-style condition decode of a 4-bit code against NZCV.
// Shared with the branch unit.
module cond_decode
  import alu_cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       taken,
  output logic       err
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    taken = 1'b0;
    err   = 1'b0;
    unique case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_CS: taken = c;
      COND_CC: taken = ~c;
      COND_MI: taken = n;
      COND_PL: taken = ~n;
      COND_VS: taken = v;
      COND_VC: taken = ~v;
      COND_HI: taken = c & ~z;
      COND_LS: taken = ~c | z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = ~z & (n == v);
      COND_LE: taken = z | (n != v);
      COND_AL: taken = 1'b1;
      COND_NV: err   = 1'b1;
      default: err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_flag_eval.sv
// Holds the NZCV register and answers condition requests against it, waiting
// for in-flight compares. Define FLAG_FWD_EN to forward same-cycle flags.
module cond_flag_eval
  import alu_cond_pkg::*;
#(
  parameter int unsigned PEND_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flg_pend,
  input  logic             flg_valid,
  input  logic             flg_n,
  input  logic             flg_z,
  input  logic             flg_c,
  input  logic             flg_v,
  cond_flag_eval_if.slave  bus,
  output logic [3:0]       flags_out,
  output logic             busy
);

  localparam int unsigned CNT_W = (PEND_TIMEOUT > 1) ? $clog2(PEND_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PEND_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       flags_q;
  logic             flags_ok_q, flags_ok_d;
  logic [3:0]       cond_q, cond_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             taken_q, taken_d;
  logic             err_q, err_d;

  logic [3:0] flg_in;
  logic [3:0] eval_flags;
  logic       eval_ok;
  logic [3:0] dec_cond;
  logic       dec_taken, dec_err;
  logic       accept;

  assign flg_in = {flg_n, flg_z, flg_c, flg_v};

`ifdef FLAG_FWD_EN
  // Flags arriving alongside a new pend are older than that compare: never forward them.
  logic fwd;
  assign fwd        = flg_valid & ~flg_pend;
  assign eval_flags = fwd ? flg_in : flags_q;
  assign eval_ok    = fwd | flags_ok_q;
`else
  assign eval_flags = flags_q;
  assign eval_ok    = flags_ok_q;
`endif

  assign accept   = bus.req_valid && (state_q == S_IDLE);
  assign dec_cond = (state_q == S_IDLE) ? bus.req_cond : cond_q;

  cond_decode u_decode (
    .cond  (dec_cond),
    .nzcv  (eval_flags),
    .taken (dec_taken),
    .err   (dec_err)
  );

  assign flags_ok_d = flg_pend ? 1'b0 : (flg_valid ? 1'b1 : flags_ok_q);

  always_comb begin
    state_d = state_q;
    cond_d  = cond_q;
    cnt_d   = cnt_q;
    taken_d = taken_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cond_d = bus.req_cond;
          cnt_d  = '0;
          if (eval_ok) begin
            state_d = S_RESP;
            taken_d = dec_taken;
            err_d   = dec_err;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (eval_ok) begin
          state_d = S_RESP;
          taken_d = dec_taken;
          err_d   = dec_err;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_RESP;
          taken_d = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      flags_q    <= 4'b0000;
      flags_ok_q <= 1'b0;
      cond_q     <= 4'h0;
      cnt_q      <= '0;
      taken_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      flags_ok_q <= flags_ok_d;
      cond_q     <= cond_d;
      cnt_q      <= cnt_d;
      taken_q    <= taken_d;
      err_q      <= err_d;
      if (flg_valid) flags_q <= flg_in;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.res_valid = (state_q == S_RESP);
  assign bus.res_taken = taken_q;
  assign bus.res_err   = err_q;
  assign flags_out     = flags_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_cond_flag_eval.sv
// Directed bench for cond_flag_eval with a result scoreboard; honours FLAG_FWD_EN.
module tb_cond_flag_eval;
  import alu_cond_pkg::*;

  localparam int unsigned PT = 16;
`ifdef FLAG_FWD_EN
  localparam int FWD_LAT = 0;
`else
  localparam int FWD_LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flg_pend = 1'b0;
  logic       flg_valid = 1'b0;
  logic       flg_n = 1'b0, flg_z = 1'b0, flg_c = 1'b0, flg_v = 1'b0;
  logic [3:0] flags_out;
  logic       busy;

  cond_flag_eval_if bus ();

  cond_flag_eval #(.PEND_TIMEOUT(PT)) dut (
    .clk       (clk),
    .rst       (rst),
    .flg_pend  (flg_pend),
    .flg_valid (flg_valid),
    .flg_n     (flg_n),
    .flg_z     (flg_z),
    .flg_c     (flg_c),
    .flg_v     (flg_v),
    .bus       (bus),
    .flags_out (flags_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;
  logic [1:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic pend, input logic valid, input logic [3:0] nzcv);
    flg_pend  = pend;
    flg_valid = valid;
    {flg_n, flg_z, flg_c, flg_v} = nzcv;
    tick();
    flg_pend  = 1'b0;
    flg_valid = 1'b0;
  endtask

  task automatic accept(input string tag, input logic [3:0] cond, input logic t,
                        input logic e);
    bus.req_valid = 1'b1;
    bus.req_cond  = cond;
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    sb_q.push_back({t, e});
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Extra cycles beyond the current sample until res_valid, then score the result.
  task automatic wait_res(input string tag, input int exp_lat);
    int n;
    logic [1:0] e;
    n = 0;
    while (!bus.res_valid && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 2'bxx;
    chk({tag, "_taken"}, 32'(bus.res_taken), 32'(e[1]));
    chk({tag, "_err"}, 32'(bus.res_err), 32'(e[0]));
  endtask

  task automatic run_req(input string tag, input logic [3:0] cond, input logic t,
                         input logic e);
    accept(tag, cond, t, e);
    wait_res(tag, 0);
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_res_taken"}, 32'(bus.res_taken), 32'd0);
    chk({tag, "_res_err"}, 32'(bus.res_err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_flags"}, 32'(flags_out), 32'd0);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_cond  = 4'h0;
    bus.res_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Z set
    set_flags(1'b0, 1'b1, 4'b0100);
    chk("t1_flags", 32'(flags_out), 32'h4);
    run_req("t1_eq", COND_EQ, 1'b1, 1'b0);
    run_req("t1_ne", COND_NE, 1'b0, 1'b0);

    // N=V, Z clear
    set_flags(1'b0, 1'b1, 4'b1001);
    run_req("t2_ge", COND_GE, 1'b1, 1'b0);
    run_req("t2_lt", COND_LT, 1'b0, 1'b0);
    run_req("t2_gt", COND_GT, 1'b1, 1'b0);
    run_req("t2_nv", COND_NV, 1'b0, 1'b1);

    // Stale flags: request waits for the compare result
    set_flags(1'b1, 1'b0, 4'b0000);
    accept("t3_hi", COND_HI, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_wait_valid", 32'(bus.res_valid), 32'd0);
    chk("t3_wait_ready", 32'(bus.req_ready), 32'd0);
    set_flags(1'b0, 1'b1, 4'b0010);
    wait_res("t3_hi", FWD_LAT);
    tick();

    // Timeout
    set_flags(1'b1, 1'b0, 4'b0000);
    accept("t4_al", COND_AL, 1'b0, 1'b1);
    wait_res("t4_al", PT);
    chk("t4_flags", 32'(flags_out), 32'h2);
    tick();

    // Backpressure
    set_flags(1'b0, 1'b1, 4'b0011);
    bus.res_ready = 1'b0;
    accept("t5_vs", COND_VS, 1'b1, 1'b0);
    wait_res("t5_vs", 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_hold_valid", 32'(bus.res_valid), 32'd1);
      chk("t5_hold_taken", 32'(bus.res_taken), 32'd1);
      chk("t5_hold_err", 32'(bus.res_err), 32'd0);
      chk("t5_hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    tick();
    chk("t5_done_valid", 32'(bus.res_valid), 32'd0);
    chk("t5_done_ready", 32'(bus.req_ready), 32'd1);

    // Pend and valid together: flags load, but remain stale
    set_flags(1'b1, 1'b1, 4'b1100);
    chk("t5_pv_flags", 32'(flags_out), 32'hC);
    accept("t5_eq", COND_EQ, 1'b1, 1'b0);
    chk("t5_eq_waits", 32'(bus.res_valid), 32'd0);
    chk("t5_eq_busy", 32'(busy), 32'd1);
    tick();
    set_flags(1'b0, 1'b1, 4'b1100);
    wait_res("t5_eq", FWD_LAT);
    tick();

    // Reset during WAIT
    set_flags(1'b1, 1'b0, 4'b0000);
    accept("t6_w", COND_AL, 1'b1, 1'b0);
    tick();
    tick();
    chk("t6_w_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("t6_rst_wait");
    sb_q.delete();

    // Reset during RESP
    set_flags(1'b0, 1'b1, 4'b0100);
    bus.res_ready = 1'b0;
    accept("t6_r", COND_EQ, 1'b1, 1'b0);
    chk("t6_r_valid", 32'(bus.res_valid), 32'd1);
    chk("t6_r_taken", 32'(bus.res_taken), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.res_ready = 1'b1;
    chk_reset_outputs("t6_rst_resp");
    sb_q.delete();

    // flags_ok cleared by reset: next request must wait
    accept("t6_after", COND_AL, 1'b1, 1'b0);
    chk("t6_after_waits", 32'(bus.res_valid), 32'd0);
    chk("t6_after_busy", 32'(busy), 32'd1);
    tick();
    set_flags(1'b0, 1'b1, 4'b0000);
    wait_res("t6_after", FWD_LAT);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
